// File: rtl/pipelined_barrel_shifter_if.sv
// Issue/result channel of the pipelined barrel shifter.
//   master : issuing side   (drives flush, in_*, out_ready)
//   slave  : the shifter    (drives in_ready, out_valid, out_data, out_tag)
// in_op encoding: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
interface pipelined_barrel_shifter_if #(
  parameter int WIDTH     = 64,
  parameter int TAG_WIDTH = 6
);
  localparam int SHW = $clog2(WIDTH);

  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_data;
  logic [SHW-1:0]       in_shamt;
  logic [1:0]           in_op;
  logic [TAG_WIDTH-1:0] in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_data;
  logic [TAG_WIDTH-1:0] out_tag;

  modport master (
    output flush, in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  flush, in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: log2(WIDTH) power-of-two shift stages, grouped
// STAGES_PER_REG at a time between pipeline registers, with valid/ready
// flow control, tag pass-through and flush.
// Ports:
//   clk   - clock, rising edge
//   reset - synchronous, active high; clears valids, data and tags
//   bus   - pipelined_barrel_shifter_if.slave (issue + result channels, flush)
// Every mode is computed as a right shift: SLL bit-reverses on entry and
// again before the last register, so one shift network serves all four.

// One group of shift stages [LO, HI) feeding a pipeline register.
module pipelined_barrel_shifter_grp #(
  parameter int WIDTH = 64,
  parameter int LO    = 0,
  parameter int HI    = 1,
  parameter bit FIRST = 1'b0,
  parameter bit LAST  = 1'b0
) (
  input  logic [WIDTH-1:0] d_in,
  input  logic [HI-LO-1:0] shamt,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] d_out
);
  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = d[WIDTH-1-i];
    return r;
  endfunction

  // Right shift by sh; vacated top bits come from fill. SRA keeps the
  // current MSB, which is always the original sign bit.
  function automatic logic [WIDTH-1:0] stage_shift(input logic [WIDTH-1:0] d,
                                                   input int sh,
                                                   input logic [1:0] mode);
    logic [WIDTH-1:0] fill;
    case (mode)
      OP_SRA:  fill = {WIDTH{d[WIDTH-1]}};
      OP_ROR:  fill = d;
      default: fill = '0;
    endcase
    return (d >> sh) | (fill << (WIDTH - sh));
  endfunction

  always_comb begin
    d_out = d_in;
    if (FIRST && op == OP_SLL) d_out = bit_rev(d_out);
    for (int k = 0; k < HI - LO; k++)
      if (shamt[k]) d_out = stage_shift(d_out, 1 << (LO + k), op);
    if (LAST && op == OP_SLL) d_out = bit_rev(d_out);
  end
endmodule

module pipelined_barrel_shifter #(
  parameter int WIDTH          = 64,
  parameter int STAGES_PER_REG = 2,
  parameter int TAG_WIDTH      = 6
) (
  input logic                        clk,
  input logic                        reset,
  pipelined_barrel_shifter_if.slave  bus
);
  localparam int LOGW = $clog2(WIDTH);
  localparam int LAT  = (LOGW + STAGES_PER_REG - 1) / STAGES_PER_REG;

  if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("pipelined_barrel_shifter: WIDTH must be a power of two >= 2");
  end
  if (STAGES_PER_REG < 1) begin : g_bad_spr
    $error("pipelined_barrel_shifter: STAGES_PER_REG must be >= 1");
  end

  typedef struct packed {
    logic [WIDTH-1:0]     data;
    logic [LOGW-1:0]      shamt;
    logic [1:0]           op;
    logic [TAG_WIDTH-1:0] tag;
  } slot_t;

  slot_t            src      [1:LAT];  // what enters each stage group
  slot_t            nxt      [1:LAT];  // group result, next slot contents
  slot_t            slot_q   [1:LAT];
  logic [WIDTH-1:0] nxt_data [1:LAT];
  logic [LAT:1]     vld_pipe;
  logic [LAT:1]     adv;   // slot content leaves this cycle (or may, if empty)
  logic [LAT:1]     take;  // valid arriving into each slot
  logic             accept;

  for (genvar s = 1; s <= LAT; s++) begin : g_slot
    localparam int LO = (s - 1) * STAGES_PER_REG;
    localparam int HI = (s * STAGES_PER_REG < LOGW) ? s * STAGES_PER_REG : LOGW;

    if (s == 1) begin : g_head
      assign src[s] = '{data: bus.in_data, shamt: bus.in_shamt,
                        op: bus.in_op, tag: bus.in_tag};
    end else begin : g_link
      assign src[s] = slot_q[s-1];
    end

    pipelined_barrel_shifter_grp #(
      .WIDTH(WIDTH), .LO(LO), .HI(HI), .FIRST(s == 1), .LAST(s == LAT)
    ) u_grp (
      .d_in  (src[s].data),
      .shamt (src[s].shamt[HI-1:LO]),
      .op    (src[s].op),
      .d_out (nxt_data[s])
    );

    assign nxt[s] = '{data: nxt_data[s], shamt: src[s].shamt,
                      op: src[s].op, tag: src[s].tag};
  end

  // Backward advance chain: a slot moves when its successor is empty or
  // moving; the tail moves when the consumer is ready.
  always_comb begin
    adv       = '0;
    take      = '0;
    adv[LAT]  = bus.out_ready;
    for (int s = LAT - 1; s >= 1; s--) adv[s] = !vld_pipe[s+1] || adv[s+1];
    take[1]   = accept;
    for (int s = 2; s <= LAT; s++) take[s] = vld_pipe[s-1];
  end

  // Depends only on pipeline state, out_ready, flush and reset, never in_valid.
  assign bus.in_ready = !reset && !bus.flush && (!vld_pipe[1] || adv[1]);
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      for (int s = 1; s <= LAT; s++) slot_q[s] <= '0;
    end else begin
      for (int s = 1; s <= LAT; s++) begin
        if (!vld_pipe[s] || adv[s]) begin
          vld_pipe[s] <= take[s];
          // Payload only loads with a real operation, so a stalled or idle
          // tail keeps its last data/tag.
          if (take[s]) slot_q[s] <= nxt[s];
        end
      end
      if (bus.flush) vld_pipe <= '0;
    end
  end

  assign bus.out_valid = vld_pipe[LAT];
  assign bus.out_data  = slot_q[LAT].data;
  assign bus.out_tag   = slot_q[LAT].tag;

  // The tail's shift amount and mode are no longer needed.
  logic unused_tail;
  assign unused_tail = ^{slot_q[LAT].shamt, slot_q[LAT].op};
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
module tb_pipelined_barrel_shifter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipelined_barrel_shifter_if #(.WIDTH(8), .TAG_WIDTH(4)) bus ();

  pipelined_barrel_shifter #(.WIDTH(8), .STAGES_PER_REG(1), .TAG_WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct { logic [7:0] data; logic [3:0] tag; int cyc; } exp_t;
  exp_t       exp_q[$];
  int         nvec = 0, nerr = 0, cyc = 0;
  bit         chk_lat = 1'b0, last_acc = 1'b0;
  logic [7:0] nxt_exp;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Reference: plain shift operators on an 8-bit value.
  function automatic logic [7:0] model(input logic [1:0] op, input logic [7:0] d, input int s);
    logic [7:0] r;
    case (op)
      2'd0: r = d << s;
      2'd1: r = d >> s;
      2'd2: r = $signed(d) >>> s;
      default: r = (s == 0) ? d : ((d >> s) | (d << (8 - s)));
    endcase
    return r;
  endfunction

  task automatic drive(input logic [1:0] op, input logic [7:0] d, input int s,
                       input logic [3:0] tag, input logic [7:0] exp);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_data  = d;
    bus.in_shamt = 3'(s);
    bus.in_tag   = tag;
    nxt_exp      = exp;
  endtask

  // One clock cycle: record the handshakes that the coming edge commits.
  task automatic tick();
    exp_t e;
    #1;
    last_acc = bus.in_valid && bus.in_ready;
    if (last_acc) exp_q.push_back('{nxt_exp, bus.in_tag, cyc});
    if (bus.out_valid && bus.out_ready && !bus.flush && !reset) begin
      if (exp_q.size() == 0) check("spurious_out", {28'h0, bus.out_tag}, 32'hFFFF_FFFF);
      else begin
        e = exp_q.pop_front();
        check("out_data", {24'h0, bus.out_data}, {24'h0, e.data});
        check("out_tag", {28'h0, bus.out_tag}, {28'h0, e.tag});
        if (chk_lat) check("latency", cyc - e.cyc, 3);
      end
    end
    if (bus.flush || reset) exp_q.delete();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    int g = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    while (exp_q.size() != 0 && g < 30) begin
      tick();
      g++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [1:0] t1_op  [6] = '{2'd2, 2'd1, 2'd0, 2'd3, 2'd1, 2'd2};
  logic [7:0] t1_d   [6] = '{8'h80, 8'h80, 8'h03, 8'h81, 8'h80, 8'h80};
  int         t1_s   [6] = '{3, 3, 7, 1, 7, 7};
  logic [7:0] t1_exp [6] = '{8'hF0, 8'h10, 8'h80, 8'hC0, 8'h01, 8'hFF};
  logic [1:0] t3_op  [5];
  logic [7:0] t3_d   [5];
  int         t3_s   [5];

  initial begin
    int idx, g;
    logic [1:0] op;
    logic [7:0] d;
    int s;

    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.in_data = '0; bus.in_shamt = '0; bus.in_op = '0; bus.in_tag = '0;
    nxt_exp = '0;
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_tag", bus.out_tag, 0);
    check("rst_in_ready", bus.in_ready, 1);

    // Directed modes and shamt boundaries, one at a time, latency 3.
    chk_lat = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(t1_op[i], t1_d[i], t1_s[i], 4'(i + 1), t1_exp[i]);
      tick();
      check("t1_accept", last_acc, 1);
      drain();
    end

    // Back-to-back stream, shamt 0 identity, one result per cycle.
    for (int i = 0; i < 8; i++) begin
      drive(2'(i % 4), 8'hA5, 0, 4'(i), 8'hA5);
      check("t2_in_ready", bus.in_ready, 1);
      tick();
    end
    drain();

    // Backpressure: capacity 3, stable output while stalled.
    chk_lat = 1'b0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      t3_op[i] = 2'($urandom_range(0, 3));
      t3_d[i]  = 8'($urandom);
      t3_s[i]  = $urandom_range(0, 7);
    end
    idx = 0;
    repeat (5) begin
      drive(t3_op[idx], t3_d[idx], t3_s[idx], 4'(8 + idx), model(t3_op[idx], t3_d[idx], t3_s[idx]));
      tick();
      if (last_acc) idx++;
    end
    check("t3_accepted", idx, 3);
    check("t3_in_ready", bus.in_ready, 0);
    repeat (2) begin
      check("t3_stall_valid", bus.out_valid, 1);
      check("t3_stall_data", {24'h0, bus.out_data}, {24'h0, model(t3_op[0], t3_d[0], t3_s[0])});
      check("t3_stall_tag", bus.out_tag, 8);
      tick();
    end
    bus.out_ready = 1'b1;
    g = 0;
    while (idx < 5 && g < 20) begin
      drive(t3_op[idx], t3_d[idx], t3_s[idx], 4'(8 + idx), model(t3_op[idx], t3_d[idx], t3_s[idx]));
      tick();
      if (last_acc) idx++;
      g++;
    end
    check("t3_rest_accepted", idx, 5);
    drain();

    // Flush with three in flight and an operation offered.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(2'd1, 8'hFF, i, 4'(i + 1), model(2'd1, 8'hFF, i));
      tick();
    end
    bus.flush = 1'b1;
    drive(2'd0, 8'h11, 1, 4'hE, 8'h22);
    #1;
    check("t4_in_ready_flush", bus.in_ready, 0);
    tick();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    check("t4_not_accepted", last_acc, 0);
    check("t4_out_valid", bus.out_valid, 0);
    bus.out_ready = 1'b1;
    repeat (5) begin
      check("t4_no_stale", bus.out_valid, 0);
      tick();
    end
    chk_lat = 1'b1;
    drive(2'd3, 8'h5A, 4, 4'h7, 8'hA5);
    tick();
    drain();

    // Reset with two in flight and the tail stalled.
    chk_lat = 1'b0;
    bus.out_ready = 1'b0;
    drive(2'd1, 8'hF0, 0, 4'hC, 8'hF0);
    tick();
    drive(2'd0, 8'h01, 1, 4'hD, 8'h02);
    tick();
    bus.in_valid = 1'b0;
    tick();
    check("t5_pre_valid", bus.out_valid, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("t5_out_valid", bus.out_valid, 0);
    check("t5_out_data", bus.out_data, 0);
    check("t5_out_tag", bus.out_tag, 0);
    check("t5_in_ready", bus.in_ready, 1);

    // Random sweep over every op/shamt pair with random flow control.
    for (int n = 0; n < 256; n++) begin
      op = 2'(n % 4);
      s  = (n / 4) % 8;
      d  = 8'($urandom);
      g  = 0;
      last_acc = 1'b0;
      while (!last_acc && g < 50) begin
        drive(op, d, s, 4'(n % 16), model(op, d, s));
        bus.in_valid  = ($urandom_range(0, 3) != 0);
        bus.out_ready = 1'($urandom_range(0, 1));
        tick();
        g++;
      end
      if (!last_acc) check("t6_accept_timeout", 0, 1);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
- Parametrised successor to the single-stage fixed shifter.
- Shifts a WIDTH-bit operand by a variable amount through log2(WIDTH) fixed power-of-two shift stages, each conditioned on one shift-amount bit.
- Supports four modes (SLL, SRL, SRA, ROR) and registers between groups of stages.
- Sits in the integer execute path with a valid/ready handshake, result tag pass-through and flush, so it can serve as a multi-cycle functional unit behind the issue queue.

Parameters:
- WIDTH, 64: operand width. Must be a power of two, >= 2.
- STAGES_PER_REG, 2: number of shift stages evaluated combinationally between pipeline registers. Must be >= 1.
- TAG_WIDTH, 6: width of the opaque tag carried alongside each operation.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  drop all in-flight operations.
- in_valid  input  1  operation offered.
- in_ready  output  1  unit can accept this cycle.
- in_data  input  WIDTH  operand.
- in_shamt  input  log2(WIDTH)  shift amount, unsigned.
- in_op  input  2  mode: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
- in_tag  input  TAG_WIDTH  tag, returned unchanged.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- out_data  output  WIDTH  shifted result.
- out_tag  output  TAG_WIDTH  tag of the result.

Behaviour:
- LOGW = log2(WIDTH); LAT = ceil(LOGW / STAGES_PER_REG). The pipeline has LAT register slots, each holding a valid bit, data, remaining shamt bits, op and tag.
- Stage k (k = 0..LOGW-1) shifts by 2^k when shamt[k] = 1.
  - SRL fill: 0.
  - SRA fill: the original operand MSB.
  - ROR: bits wrap from bit 0 into the MSB.
  - SLL: the operand is bit-reversed on entry, shifted right logically, then bit-reversed before the output register.
- Stages 0..STAGES_PER_REG-1 feed slot 1, and so on. The last slot drives out_*.
- Latency: an operation accepted on the edge where in_valid && in_ready is high appears with out_valid = 1 exactly LAT cycles later when there is no backpressure. Throughput is 1 operation per cycle.
- Handshake:
  - Each slot advances when its successor is empty or is advancing.
  - The last slot is treated as advancing when out_ready = 1.
  - in_ready = !slot1_valid || slot1_advances. in_ready must not depend combinationally on in_valid.
  - out_data and out_tag hold stable while out_valid && !out_ready.
  - Operations complete in acceptance order. None are dropped or duplicated.
- Capacity: LAT operations. With out_ready held at 0, exactly LAT operations are accepted, then in_ready = 0.
- shamt = 0: out_data = in_data for all ops.
- shamt = WIDTH-1:
  - SLL yields in_data[0] in the MSB, all other bits 0.
  - SRL yields in_data[WIDTH-1] in the LSB, all other bits 0.
  - SRA yields all bits equal to the sign bit.
- flush:
  - On the edge where flush = 1, all slot valid bits clear, so out_valid = 0 the next cycle.
  - An operation offered the same cycle is not accepted: in_ready = 0 while flush = 1.
  - Data and tag registers are not cleared.
- reset: same as flush, and additionally clears all data and tag registers to 0.
  - After reset: out_valid = 0, out_data = 0, out_tag = 0, in_ready = 1 (from the first cycle after reset deasserts).
  - Reset mid-operation discards everything in flight. reset has priority over flush and over the handshake.
- Elaboration-time checks: WIDTH is a power of two and >= 2; STAGES_PER_REG >= 1.

Test Plan:
Configuration for all scenarios: WIDTH = 8, STAGES_PER_REG = 1, so LAT = 3.
1. Modes:
   - SRA 8'b1000_0000, shamt 3 -> 8'b1111_0000.
   - SRL same operand -> 8'b0001_0000.
   - SLL 8'b0000_0011, shamt 7 -> 8'b1000_0000.
   - ROR 8'b1000_0001, shamt 1 -> 8'b1100_0000.
   - Each result appears exactly 3 cycles after acceptance; tags are returned intact.
2. Streaming: issue back-to-back operations with tags 0..7 and out_ready = 1 -> one result per cycle, in tag order, starting at cycle 3. Identity check: shamt 0 on 8'hA5 -> 8'hA5 for every op.
3. Backpressure: out_ready = 0, push 5 operations -> only 3 accepted, in_ready = 0 afterwards. out_data stays stable while stalled. After out_ready = 1, results arrive in order and the remaining 2 operations are accepted.
4. Flush: 3 operations in flight, then assert flush for 1 cycle with in_valid = 1 -> out_valid = 0 next cycle, the offered operation is not accepted, and no stale result ever appears. A new operation after the flush returns at latency 3.
5. Reset mid-operation: assert reset with 2 operations in flight and out_ready = 0 -> next cycle out_valid = 0, out_data = 0, out_tag = 0, in_ready = 1.
6. Random sweep: all ops and all shamt 0..7, with random out_ready, compared against a reference model (SRA via signed shift; ROR via (x>>s)|(x<<(8-s))) -> zero mismatches, ordering preserved.
